// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode constants, nop encoding and fetch FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack imem port, fills IF/ID and keeps a
// one-entry hold buffer for a word that returns while ID is stalled.
module if_stage
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [5:0]      ifid_opcode,
  output logic [5:0]      ifid_func
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc4_q, hold_pc4_d;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state logic: redirect beats stall; an ack in a redirect cycle is dropped.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;

    if (redirect) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      valid_d = 1'b0;
      instr_d = XLEN'(NOP_INSTR);
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_plus4;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_plus4;
              state_d      = HOLD;
            end else begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = XLEN'(NOP_INSTR);
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d = 1'b1;
            instr_d = hold_instr_q;
            pc4_d   = hold_pc4_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC, IF/ID and hold-buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  // Request is decoded from state; suppressed while reset is held.
  always_comb begin
    imem_req = !rst && (state_q == FETCH);
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ifid_valid  = valid_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_opcode = instr_q[XLEN-1:XLEN-6];
  assign ifid_func   = instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed stimulus, a transaction-level model, a per-cycle
// compare process and literal checks at the interesting points.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_func;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  // Model state: fetch PC, IF/ID contents, and a queue standing in for the hold buffer.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [31:0] m_buf_word[$];
  logic [31:0] m_buf_pc4[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h8C22_0004;
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_opcode(ifid_opcode),
    .ifid_func  (ifid_func)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at every rising edge from the inputs presented for that edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_buf_word.delete(); m_buf_pc4.delete();
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_instr = 32'h0;
      m_buf_word.delete(); m_buf_pc4.delete();
    end else if (m_buf_word.size() != 0) begin
      if (!stall) begin
        m_valid = 1'b1;
        m_instr = m_buf_word.pop_front();
        m_pc4   = m_buf_pc4.pop_front();
      end
    end else if (imem_ack) begin
      if (stall) begin
        m_buf_word.push_back(mem_word(m_pc));
        m_buf_pc4.push_back(m_pc + 32'd4);
      end else begin
        m_valid = 1'b1;
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_valid = 1'b0; m_instr = 32'h0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", {31'b0, imem_req}, {31'b0, !rst && (m_buf_word.size() == 0)});
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
      chk("ifid_instr", ifid_instr, m_valid ? m_instr : 32'h0);
      chk("ifid_opcode", {26'b0, ifid_opcode}, {26'b0, m_instr[31:26]});
      chk("ifid_func", {26'b0, ifid_func}, {26'b0, m_instr[5:0]});
      if (m_valid) chk("ifid_pc4", ifid_pc4, m_pc4);
    end
  end

  // One clock: apply inputs shortly after a falling edge, return at the next falling edge.
  task automatic cyc(input logic a, input logic s, input logic r, input logic [31:0] t);
    #1;
    imem_ack = a; stall = s; redirect = r; redirect_pc = t;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_on = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("reset_valid", {31'b0, ifid_valid}, 32'd0);
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("first_addr", imem_addr, 32'h0);
    chk("first_req", {31'b0, imem_req}, 32'd1);

    // Zero-wait fetches.
    cyc(1, 0, 0, 0); chk("zw_pc4_0", ifid_pc4, 32'd4); chk("zw_valid", {31'b0, ifid_valid}, 32'd1);
    cyc(1, 0, 0, 0); chk("zw_pc4_1", ifid_pc4, 32'd8);

    // Slow memory at pc=8: three waits then ack.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("slow_addr", imem_addr, 32'h8);
      chk("slow_bubble", ifid_instr, 32'h0);
    end
    cyc(1, 0, 0, 0);
    chk("slow_pc4", ifid_pc4, 32'd12);
    chk("slow_instr", ifid_instr, 32'hFFF7_0008);

    // Ack under stall at pc=12 (lw word).
    cyc(1, 1, 0, 0);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_frozen", ifid_pc4, 32'd12);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hold_instr", ifid_instr, 32'h8C22_0004);
    chk("hold_opcode", {26'b0, ifid_opcode}, 32'h23);
    chk("hold_pc", pc, 32'd16);
    chk("hold_pc4", ifid_pc4, 32'd16);

    // Redirect overriding stall and a concurrent ack.
    cyc(1, 1, 1, 32'h40);
    chk("redir_valid", {31'b0, ifid_valid}, 32'd0);
    chk("redir_pc", pc, 32'h40);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    cyc(1, 0, 0, 0);
    chk("redir_pc4", ifid_pc4, 32'h44);
    cyc(0, 1, 0, 0);

    // Misaligned target and PC wrap.
    cyc(0, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_pc0", pc, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);

    // Redirect while in HOLD discards the buffer.
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h100);
    chk("hredir_pc", pc, 32'h100);
    chk("hredir_valid", {31'b0, ifid_valid}, 32'd0);

    // Reset while in HOLD.
    cyc(1, 1, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("rhold_pc", pc, 32'h0);
    chk("rhold_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rhold_req", {31'b0, imem_req}, 32'd0);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("rhold_nobuf", {31'b0, ifid_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("rhold_pc4", ifid_pc4, 32'd4);

    // Mixed pattern checked by the model only.
    for (int i = 0; i < 40; i++) begin
      cyc((i % 3) != 0, (i % 5) == 1, i == 20, 32'h0000_0203);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline and the producer of the `opcode`/`func` fields consumed by the control unit in ID. It owns the program counter and issues requests over a req/ack instruction-memory port with variable latency. It captures returned words into the IF/ID pipeline register and honours stall and branch/jump redirect from downstream. A one-entry hold buffer prevents loss of a word that returns while ID is stalled.

## Interface
- `XLEN`, 32, data/address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  XLEN  fetch address; always equals `pc`.
- `imem_ack`  in  1  `imem_rdata` valid this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  XLEN  instruction word.
- `stall`  in  1  hold IF/ID (load-use hazard from the hazard unit).
- `redirect`  in  1  taken beq/bne or j resolved in ID.
- `redirect_pc`  in  XLEN  target address; bits [1:0] ignored and forced to 0.
- `pc`  out  XLEN  current fetch PC.
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `ifid_instr`  out  XLEN  fetched instruction; 0 (nop) when not valid.
- `ifid_pc4`  out  XLEN  PC+4 of `ifid_instr`.
- `ifid_opcode`  out  6  `ifid_instr[31:26]`.
- `ifid_func`  out  6  `ifid_instr[5:0]`.

## Operation
- FSM states: FETCH, HOLD.
- **Reset.** `pc`=RESET_PC, state=FETCH, IF/ID cleared (valid 0, instr 0, pc4 0), hold buffer empty.
- **FETCH.** `imem_req`=1. The address is held stable until ack or redirect.
  - ack and !stall: IF/ID ← {rdata, pc+4, valid=1}; `pc` ← pc+4.
  - ack and stall: rdata → hold buffer; `pc` ← pc+4; go to HOLD; IF/ID unchanged.
  - no ack and !stall: IF/ID ← bubble (valid 0, instr 0).
  - no ack and stall: IF/ID unchanged.
- **HOLD.** `imem_req`=0.
  - stall: remain in HOLD.
  - !stall: IF/ID ← {buffer, buffered pc4, valid=1}; go to FETCH.
- **Redirect.** Priority: rst > redirect > stall.
  - `pc` ← {redirect_pc[31:2],2'b00}.
  - IF/ID ← bubble, even if stall=1.
  - Hold buffer discarded; state → FETCH.
  - An ack arriving in the same cycle is dropped.
  - Memory must accept the address change on an un-acked request; no response for the old address is accepted afterwards.
- **PC arithmetic.** Modulo 2^XLEN. 32'hFFFF_FFFC + 4 = 0.
- `ifid_opcode`/`ifid_func` are pure slices of `ifid_instr`; a bubble decodes as R-type/func 0 (nop).

## Timing
- All outputs registered except `imem_req`, which is decoded from state, and `imem_addr`, which equals `pc`.
- `imem_req`=0 while `rst`=1; `imem_req`=1 in the first cycle after reset release.
- Ack in cycle N → `ifid_valid`=1 in cycle N+1.
- Zero-wait memory (ack every cycle) sustains 1 instruction/cycle.
- Redirect in cycle N → `imem_addr`=target in N+1; the first target word reaches IF/ID no earlier than N+2.
- Stall in cycle N freezes IF/ID at the N+1 edge. Release gives the next instruction in IF/ID one cycle later, with no fetch lost or duplicated.
- Reset asserted mid-operation, including in HOLD or with a request outstanding, takes effect at the next edge; buffer contents are lost.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_RTYPE` 6'b000000, `OP_LW` 6'b100011, `OP_SW` 6'b101011, `OP_BEQ` 6'b000100, `OP_BNE` 6'b000101, `OP_J` 6'b000010;
  - `NOP_INSTR` 32'h0000_0000;
  - enum `fetch_state_t` {FETCH, HOLD}.
- Single flat module; no sub-module.

## Test plan
- **Reset.** Reset with RESET_PC=0, zero-wait memory → cycle 1: `imem_addr`=0; cycles 2-4: `ifid_pc4`=4, 8, 12; `ifid_valid`=1 throughout.
- **Slow memory.** Ack 3 cycles after req at pc=8 → `imem_addr` stays 8 for 3 cycles; IF/ID bubbles (`ifid_instr`=0); word appears with `ifid_pc4`=12 the cycle after ack.
- **Ack under stall.** Ack while stall=1 with word 32'h8C220004 (lw) → HOLD, `imem_req`=0; 2 cycles later stall drops → `ifid_instr`=32'h8C220004, `ifid_opcode`=6'b100011, next fetch at pc+4.
- **Redirect over stall.** redirect=1 with redirect_pc=32'h40, stall=1, ack=1 → next cycle `ifid_valid`=0, `pc`=32'h40, acked word dropped, state FETCH.
- **Misaligned target / wrap.** redirect_pc=32'hFFFF_FFFF → `pc`=32'hFFFF_FFFC; after one ack `pc`=0 and `ifid_pc4`=0.
- **Reset in HOLD.** rst=1 while in HOLD → next cycle `pc`=RESET_PC, `ifid_valid`=0, `imem_req`=0; the buffered word never appears.
